// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: FSM state, error codes and sizing helpers shared by
// the APB4 memory completer and its storage array.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

    // One-hot error causes; any nonzero code yields PSLVERR.
    localparam logic [3:0] ERR_NONE  = 4'b0000;
    localparam logic [3:0] ERR_ALIGN = 4'b0001;
    localparam logic [3:0] ERR_RANGE = 4'b0010;
    localparam logic [3:0] ERR_RO    = 4'b0100;
    localparam logic [3:0] ERR_PROT  = 4'b1000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_slave_sram.sv
// apb_slave_sram: word memory with byte-enable write and a registered
// read port that can be cleared.
module apb_slave_sram
    import apb_slave_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int STRB_W = strb_w(DATA_W),
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [STRB_W-1:0] be_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] fwd;

    // A read landing on the edge that commits a write sees the new bytes.
    always_comb begin
        fwd = mem_q[raddr_i];
        for (int b = 0; b < STRB_W; b++) begin
            if (we_i && be_i[b] && (waddr_i == raddr_i))
                fwd[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (clr_i)     rdata_d = '0;
        else if (re_i) rdata_d = fwd;
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        for (int b = 0; b < STRB_W; b++) begin
            if (we_i && be_i[b])
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb4_slave_mem.sv
// apb4_slave_mem: APB4 completer over a local word memory with wait states,
// strobes and error decode. Define APB_PROT_CHECK_EN to reject PPROT[0]=0.
module apb4_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0,
    localparam int STRB_W     = strb_w(DATA_W)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [STRB_W-1:0] PSTRB,
    input  logic [2:0]        PPROT,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int LSB   = clog2(STRB_W);
    localparam int IDX_W = clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] ALIGN_M = ADDR_W'((1 << LSB) - 1);

    apb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              ready_q, slverr_q;

    logic setup, take, fin_live, fin_lat, fin, fin_wr, fin_err;
    logic err_live, err_lat, re, clr, we;
    logic ro_live, ro_lat, prot_live, prot_lat;
    logic [IDX_W-1:0] raddr, waddr;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> LSB);
    endfunction

    function automatic logic [3:0] code_of(input logic [ADDR_W-1:0] a,
                                           input logic ro,
                                           input logic pr);
        logic [3:0] c;
        c = ERR_NONE;
        if ((a & ALIGN_M) != '0)        c = c | ERR_ALIGN;
        if ((a >> (LSB + IDX_W)) != '0) c = c | ERR_RANGE;
        if (ro)                         c = c | ERR_RO;
        if (pr)                         c = c | ERR_PROT;
        return c;
    endfunction

    if (RO_WORDS > 0) begin : g_ro
        assign ro_live = PWRITE && (32'(idx_of(PADDR)) < RO_WORDS);
        assign ro_lat  = wr_q && (32'(idx_of(addr_q)) < RO_WORDS);
    end else begin : g_rw
        assign ro_live = 1'b0;
        assign ro_lat  = 1'b0;
    end

`ifdef APB_PROT_CHECK_EN
    logic prot0_q;
    logic unused_prot;
    assign unused_prot = ^PPROT[2:1];
    always_ff @(posedge PCLK) begin
        if (take) prot0_q <= PPROT[0];
    end
    assign prot_live = !PPROT[0];
    assign prot_lat  = !prot0_q;
`else
    logic unused_prot;
    assign unused_prot = ^PPROT;
    assign prot_live = 1'b0;
    assign prot_lat  = 1'b0;
`endif

    assign setup    = PSEL && !PENABLE;
    assign err_live = code_of(PADDR, ro_live, prot_live) != ERR_NONE;
    assign err_lat  = code_of(addr_q, ro_lat, prot_lat) != ERR_NONE;

    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (!setup)          state_d = IDLE;
                else if (WS == 4'd0) state_d = DONE;
                else                 state_d = ACCESS;
            end
            ACCESS: begin
                if (!PSEL)                          state_d = IDLE;
                else if (PENABLE && cnt_q == 4'd1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-wait transfers complete on the setup edge using live bus values.
    always_comb begin
        take     = setup && (state_q != ACCESS);
        fin_live = take && (WS == 4'd0);
        fin_lat  = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd1);
        fin      = fin_live || fin_lat;
        fin_wr   = fin_live ? PWRITE : wr_q;
        fin_err  = fin_live ? err_live : err_lat;
        raddr    = fin_live ? idx_of(PADDR) : idx_of(addr_q);
        waddr    = idx_of(addr_q);
        re       = fin && !fin_wr && !fin_err;
        clr      = PRESET || (fin && !fin_wr && fin_err);
        we       = (state_q == DONE) && wr_q && !slverr_q && !PRESET;
        cnt_d    = cnt_q;
        if (take)
            cnt_d = WS;
        else if ((state_q == ACCESS) && PSEL && PENABLE && (cnt_q != 4'd0))
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ready_q  <= fin;
            slverr_q <= fin && fin_err;
        end
    end

    always_ff @(posedge PCLK) begin
        if (take) begin
            addr_q  <= PADDR;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    apb_slave_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk_i   (PCLK),
        .we_i    (we),
        .waddr_i (waddr),
        .be_i    (strb_q),
        .wdata_i (wdata_q),
        .re_i    (re),
        .clr_i   (clr),
        .raddr_i (raddr),
        .rdata_o (PRDATA)
    );

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// tb_apb4_slave_mem: two completers (0 and 3 wait states) driven by an APB
// master task and checked against a byte-level memory model.
module tb_apb4_slave_mem;

    localparam int DEPTH = 1024;
`ifdef APB_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        PCLK;
    logic        preset;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [2];
    logic [1:0]  pready;
    logic [1:0]  pslverr;

    logic [7:0]  mdl [int];
    int          n_tests = 0;
    int          n_fail  = 0;

    apb4_slave_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .RO_WORDS(4)
    ) u_dut0 (
        .PCLK(PCLK), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0])
    );

    apb4_slave_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(3), .RO_WORDS(0)
    ) u_dut1 (
        .PCLK(PCLK), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1])
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int ro_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic int key(input int d, input logic [31:0] a);
        return d * 32'h10000 + int'(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One APB transfer starting at a falling edge; returns in its PREADY cycle
    // (b2b) or after one idle cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pp, input bit b2b,
                        output logic [31:0] rd);
        int          n;
        int          ws;
        bit          err;
        logic [31:0] ex, mk;
        ws  = ws_of(d);
        err = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH) ||
              (wr && ((a >> 2) < ro_of(d))) || (PROT_EN && !pp[0]);
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        pprot   = pp;
        @(negedge PCLK);
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        n = 1;
        while (pready[d] !== 1'b1 && n < ws + 6) begin
            @(negedge PCLK);
            n++;
        end
        check($sformatf("ready_lat d%0d", d), n, ws + 1);
        check($sformatf("slverr d%0d a=%0h", d, a), pslverr[d], err);
        rd = prdata[d];
        if (!wr) begin
            ex = '0;
            mk = '1;
            if (!err) begin
                for (int b = 0; b < 4; b++) begin
                    if (mdl.exists(key(d, a) + b)) ex[8*b +: 8] = mdl[key(d, a) + b];
                    else                           mk[8*b +: 8] = 8'h00;
                end
            end
            if (mk != '0)
                check($sformatf("rdata d%0d a=%0h", d, a), rd & mk, ex & mk);
        end else if (!err) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl[key(d, a) + b] = wd[8*b +: 8];
        end
        if (!b2b) begin
            psel    = '0;
            penable = 1'b0;
            @(negedge PCLK);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          r;
        preset  = 1'b1;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = 3'b011;
        repeat (3) @(negedge PCLK);
        preset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready d%0d", d), pready[d], 1'b0);
            check($sformatf("rst_slverr d%0d", d), pslverr[d], 1'b0);
            check($sformatf("rst_rdata d%0d", d), prdata[d], 32'h0);
        end
        @(negedge PCLK);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                xfer(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 3'b011,
                     bit'($urandom_range(0, 1)), rd);

        // Zero-wait basic write/read and strobe merge.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b011, 1'b0, rd);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        check("rd_deadbeef", rd, 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h40, 32'h11223344, 4'hF, 3'b011, 1'b0, rd);
        xfer(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'h5, 3'b011, 1'b0, rd);
        xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 3'b011, 1'b0, rd);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b011, 1'b0, rd);
        check("strb_merge", rd, 32'h11BB33DD);

        // Error responses.
        xfer(0, 1'b0, 32'h1002, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        check("misalign_rdata", rd, 32'h0);
        xfer(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 3'b011, 1'b0, rd);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        xfer(0, 1'b1, 32'h08, 32'h66666666, 4'hF, 3'b011, 1'b0, rd);
        xfer(0, 1'b1, 32'h0C, 32'h77777777, 4'hF, 3'b011, 1'b0, rd);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b0, rd);

        // Back-to-back write then read of the same word.
        xfer(0, 1'b1, 32'h44, 32'hCAFEF00D, 4'hF, 3'b011, 1'b1, rd);
        xfer(0, 1'b0, 32'h44, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        check("b2b_rd d0", rd, 32'hCAFEF00D);
        xfer(1, 1'b1, 32'h48, 32'h0BADF00D, 4'hF, 3'b011, 1'b1, rd);
        xfer(1, 1'b0, 32'h48, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        check("b2b_rd d1", rd, 32'h0BADF00D);

        // Wait-state completer: data path, errors, abort.
        xfer(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 3'b011, 1'b0, rd);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        check("ws3_rd", rd, 32'h12345678);
        xfer(1, 1'b0, 32'h1002, 32'h0, 4'h0, 3'b011, 1'b0, rd);

        psel    = 2'b10;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h20;
        pwdata  = 32'hBADC0DE5;
        pstrb   = 4'hF;
        pprot   = 3'b011;
        @(negedge PCLK);
        penable = 1'b1;
        check("abort_rdy1", pready[1], 1'b0);
        @(negedge PCLK);
        check("abort_rdy2", pready[1], 1'b0);
        psel    = '0;
        penable = 1'b0;
        @(negedge PCLK);
        check("abort_rdy3", pready[1], 1'b0);
        check("abort_err", pslverr[1], 1'b0);
        @(negedge PCLK);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b011, 1'b0, rd);
        check("abort_nowrite", rd, 32'h12345678);

        // Reset in the middle of an access phase.
        psel    = 2'b10;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h20;
        @(negedge PCLK);
        penable = 1'b1;
        @(negedge PCLK);
        preset = 1'b1;
        @(negedge PCLK);
        preset  = 1'b0;
        psel    = '0;
        penable = 1'b0;
        check("midrst_ready", pready[1], 1'b0);
        check("midrst_err", pslverr[1], 1'b0);
        check("midrst_rdata", prdata[1], 32'h0);
        @(negedge PCLK);

        // Randomized traffic on both completers.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 60; t++) begin
                r = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 15) * 4);
                if (r == 0)      a = a + 32'h1000;
                else if (r == 1) a = a + 32'($urandom_range(1, 3));
                xfer(d, bit'($urandom_range(0, 1)), a, $urandom,
                     4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b011,
                     bit'($urandom_range(0, 1)), rd);
            end
            psel    = '0;
            penable = 1'b0;
            @(negedge PCLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
